// File: rtl/img_pipe_defs.sv
// img_pipe_defs: shared mode encodings and default image geometry for the binary pixel pipeline
// Contents: morph_mode_e operator select, IMG_H_DEF/IMG_V_DEF image size, CNT_W_DEF counter width
package img_pipe_defs;
  typedef enum logic [1:0] {
    MORPH_PASS   = 2'b00,
    MORPH_ERODE  = 2'b01,
    MORPH_DILATE = 2'b10,
    MORPH_MAJ    = 2'b11
  } morph_mode_e;
  localparam logic [10:0] IMG_H_DEF = 11'd964;
  localparam logic [10:0] IMG_V_DEF = 11'd1444;
  localparam int CNT_W_DEF = 21;
endpackage

// File: rtl/popcount9.sv
// popcount9: combinational count of set bits in a 9-bit window
// Ports: i_bits window taps in, o_cnt number of ones (0..9)
module popcount9 (
  input  logic [8:0] i_bits,
  output logic [3:0] o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 9; i++) o_cnt = o_cnt + {3'b000, i_bits[i]};
  end
endmodule

// File: rtl/bin_morph_3x3.sv
// bin_morph_3x3: frame-latched 3x3 binary morphology with border masking and per-frame foreground count
// Ports: clk/rst_n (async active-low); mode operator select; in_* sync/data from window generator;
//        p11..p33 window taps; post_* 1-cycle delayed sync/data and result bit;
//        frame_fg_cnt/frame_done foreground count of the last completed frame and its update strobe
module bin_morph_3x3
  import img_pipe_defs::*;
#(
  parameter logic [10:0] IMG_H = IMG_H_DEF,
  parameter logic [10:0] IMG_V = IMG_V_DEF,
  parameter int          CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_vs,
  input  logic             in_hs,
  input  logic             in_clken,
  input  logic [15:0]      in_img_data,
  input  logic             p11, p12, p13,
  input  logic             p21, p22, p23,
  input  logic             p31, p32, p33,
  output logic             post_vs,
  output logic             post_hs,
  output logic             post_clken,
  output logic [15:0]      post_img_data,
  output logic             post_imgbit,
  output logic [CNT_W-1:0] frame_fg_cnt,
  output logic             frame_done
);
  logic             w_vs_rise, w_vs_fall, w_hs_fall, w_inside, w_res, w_inc;
  logic [8:0]       w_win;
  logic [3:0]       w_pop;
  logic [10:0]      r_col, r_row;
  logic [CNT_W-1:0] r_acc, w_acc_nxt;
  morph_mode_e      r_mode;
  // post_vs/post_hs double as the previous-cycle sync values for edge detection
  assign w_vs_rise = in_vs & ~post_vs;
  assign w_vs_fall = ~in_vs & post_vs;
  assign w_hs_fall = ~in_hs & post_hs;
  assign w_inside  = (r_col >= 11'd2) & (r_row >= 11'd2);
  assign w_win     = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
  popcount9 u_pop (.i_bits(w_win), .o_cnt(w_pop));
  always_comb begin
    w_res = r_mode == MORPH_PASS   ? p22 :
            r_mode == MORPH_ERODE  ? &w_win :
            r_mode == MORPH_DILATE ? |w_win : (w_pop >= 4'd5);
  end
  // the increment pending this cycle is folded into the frame total on vs_fall
  assign w_inc     = post_clken & post_hs & post_imgbit;
  assign w_acc_nxt = (w_inc & ~&r_acc) ? r_acc + CNT_W'(1) : r_acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vs       <= 1'b0;
      post_hs       <= 1'b0;
      post_clken    <= 1'b0;
      post_img_data <= '0;
      post_imgbit   <= 1'b0;
      frame_fg_cnt  <= '0;
      frame_done    <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_acc         <= '0;
      r_mode        <= MORPH_PASS;
    end else begin
      post_vs       <= in_vs;
      post_hs       <= in_hs;
      post_clken    <= in_clken;
      post_img_data <= in_img_data;
      if (w_vs_rise) r_mode <= morph_mode_e'(mode);
      r_col <= !in_hs ? '0 : (in_clken && r_col != IMG_H) ? r_col + 11'd1 : r_col;
      r_row <= (w_vs_rise || !in_vs) ? '0 : (w_hs_fall && r_row != IMG_V) ? r_row + 11'd1 : r_row;
      post_imgbit <= !in_hs ? 1'b0 : in_clken ? (w_res & w_inside) : post_imgbit;
      r_acc <= w_vs_rise ? '0 : w_acc_nxt;
      frame_done <= w_vs_fall;
      if (w_vs_fall) frame_fg_cnt <= w_acc_nxt;
    end
  end
endmodule

// File: tb/tb_bin_morph_3x3.sv
// tb_bin_morph_3x3: scoreboard bench for bin_morph_3x3 on an 8x6 image
module tb_bin_morph_3x3;
  localparam int H = 8;
  localparam int V = 6;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        in_vs = 1'b0, in_hs = 1'b0, in_clken = 1'b0;
  logic [15:0] in_img_data = '0;
  logic        p11 = 0, p12 = 0, p13 = 0, p21 = 0, p22 = 0, p23 = 0, p31 = 0, p32 = 0, p33 = 0;
  logic        post_vs, post_hs, post_clken, post_imgbit, frame_done;
  logic [15:0] post_img_data;
  logic [20:0] frame_fg_cnt;
  int n_cmp = 0, n_err = 0;
  bit exp_bq[$], got_bq[$];
  int exp_cq[$], got_cq[$];

  bin_morph_3x3 #(.IMG_H(11'd8), .IMG_V(11'd6), .CNT_W(21)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_vs(in_vs), .in_hs(in_hs), .in_clken(in_clken),
    .in_img_data(in_img_data), .p11(p11), .p12(p12), .p13(p13), .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33), .post_vs(post_vs), .post_hs(post_hs), .post_clken(post_clken),
    .post_img_data(post_img_data), .post_imgbit(post_imgbit), .frame_fg_cnt(frame_fg_cnt),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (post_hs && post_clken) got_bq.push_back(post_imgbit);
    if (frame_done) got_cq.push_back(int'(frame_fg_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vs, input logic hs, input logic ck, input logic [8:0] t, input logic [15:0] d);
    in_vs = vs;
    in_hs = hs;
    in_clken = ck;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = t;
    in_img_data = d;
    tick();
  endtask

  function automatic logic [8:0] taps_of(input int pat, input int r, input int c);
    logic [8:0] t;
    t = '0;
    if (pat == 0) t = 9'h1FF;
    if (pat == 1 && r == 3 && c == 4) t = 9'b001_000_000;
    if (pat == 2 && r == 3 && c == 4) t = 9'b000_001_111;
    if (pat == 2 && r == 3 && c == 5) t = 9'b000_011_111;
    if (pat == 3) t = 9'($urandom);
    return t;
  endfunction

  function automatic bit model(input logic [1:0] m, input logic [8:0] t, input int r, input int c);
    bit res;
    case (m)
      2'b00:   res = t[4];
      2'b01:   res = &t;
      2'b10:   res = |t;
      default: res = $countones(t) >= 5;
    endcase
    return res && r >= 2 && c >= 2;
  endfunction

  task automatic run_frame(input int pat, input bit abrupt, input bit gap, input int chg_line, input logic [1:0] chg_mode);
    int cnt;
    bit b, last;
    logic [1:0] eff;
    logic [8:0] t;
    cnt = 0;
    last = 0;
    eff = mode;
    drive(1, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    for (int r = 0; r < V; r++) begin
      if (r == chg_line) mode = chg_mode;
      for (int c = 0; c < H; c++) begin
        t = taps_of(pat, r, c);
        if (gap && r == 3 && (c == 1 || c == 5)) begin
          for (int g = 0; g < 3; g++) begin
            drive(1, 1, 0, t, 16'h0BAD + 16'(g));
            n_cmp++;
            if (post_imgbit !== last || post_clken !== 1'b0 || post_img_data !== 16'h0BAD + 16'(g)) begin
              n_err++;
              $display("FAIL clken_gap r%0d c%0d g%0d: imgbit=%0b clken=%0b data=%h, want imgbit=%0b clken=0 data=%h",
                       r, c, g, post_imgbit, post_clken, post_img_data, last, 16'h0BAD + 16'(g));
            end
          end
        end
        b = model(eff, t, r, c);
        exp_bq.push_back(b);
        cnt += int'(b);
        last = b;
        drive(1, 1, 1, t, 16'(r * 16 + c));
      end
      if (!(abrupt && r == V - 1)) begin
        drive(1, 0, 0, '0, '0);
        if (r == 3) begin
          n_cmp++;
          if (post_imgbit !== 1'b0 || post_hs !== 1'b0) begin
            n_err++;
            $display("FAIL hs_low_zero: imgbit=%0b hs=%0b, want 0/0", post_imgbit, post_hs);
          end
        end
        drive(1, 0, 0, '0, '0);
      end
    end
    exp_cq.push_back(cnt);
    drive(0, 0, 0, '0, '0);
    drive(0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 9'h1FF, 16'hFFFF);
    drive(1, 1, 1, 9'h1FF, 16'hFFFF);
    drive(1, 1, 1, 9'h1FF, 16'hFFFF);
    n_cmp++;
    if ({post_vs, post_hs, post_clken, post_imgbit, frame_done} !== 5'b0 || post_img_data !== 16'h0 || frame_fg_cnt !== 21'h0) begin
      n_err++;
      $display("FAIL reset_outputs: vs/hs/ck/bit/done=%b data=%h cnt=%0d, want all 0",
               {post_vs, post_hs, post_clken, post_imgbit, frame_done}, post_img_data, frame_fg_cnt);
    end
    rst_n = 1'b1;
    in_img_data = 16'hA5C3;
    n_cmp++;
    if (post_vs !== 1'b0 || post_img_data !== 16'h0) begin
      n_err++;
      $display("FAIL latency_before_edge: vs=%0b data=%h, want 0/0000", post_vs, post_img_data);
    end
    exp_bq.push_back(1'b0);
    tick();
    n_cmp++;
    if ({post_vs, post_hs, post_clken} !== 3'b111 || post_img_data !== 16'hA5C3 || post_imgbit !== 1'b0) begin
      n_err++;
      $display("FAIL latency_after_edge: vs/hs/ck=%b data=%h bit=%0b, want 111/a5c3/0",
               {post_vs, post_hs, post_clken}, post_img_data, post_imgbit);
    end
    exp_cq.push_back(0);
    drive(0, 0, 0, '0, '0);
    n_cmp++;
    if (post_vs !== 1'b0 || frame_done !== 1'b1 || frame_fg_cnt !== 21'd0) begin
      n_err++;
      $display("FAIL first_vs_fall: vs=%0b done=%0b cnt=%0d, want 0/1/0", post_vs, frame_done, frame_fg_cnt);
    end
    drive(0, 0, 0, '0, '0);
  endtask

  task automatic test_erode_border();
    mode = 2'b01;
    run_frame(0, 1, 0, -1, 2'b00);
    n_cmp++;
    if (exp_cq[$] !== 24) begin
      n_err++;
      $display("FAIL erode_model_count: got %0d, want 24", exp_cq[$]);
    end
  endtask

  task automatic test_dilate_erode_single();
    mode = 2'b10;
    run_frame(1, 0, 0, -1, 2'b00);
    mode = 2'b01;
    run_frame(1, 0, 0, -1, 2'b00);
  endtask

  task automatic test_majority();
    mode = 2'b11;
    run_frame(2, 0, 0, -1, 2'b00);
  endtask

  task automatic test_mode_midframe();
    mode = 2'b00;
    run_frame(3, 0, 0, 2, 2'b01);
    run_frame(3, 0, 0, -1, 2'b00);
  endtask

  task automatic test_clken_gap();
    mode = 2'b00;
    run_frame(0, 0, 1, -1, 2'b00);
  endtask

  task automatic test_back_to_back();
    mode = 2'b11;
    run_frame(3, 1, 0, -1, 2'b00);
    mode = 2'b10;
    run_frame(3, 0, 1, -1, 2'b00);
  endtask

  task automatic test_pixels();
    n_cmp++;
    if (got_bq.size() !== exp_bq.size()) begin
      n_err++;
      $display("FAIL pixel_count: got %0d pixels, want %0d", got_bq.size(), exp_bq.size());
    end
    for (int i = 0; i < exp_bq.size() && i < got_bq.size(); i++) begin
      n_cmp++;
      if (got_bq[i] !== exp_bq[i]) begin
        n_err++;
        $display("FAIL pixel[%0d]: got %0b, want %0b", i, got_bq[i], exp_bq[i]);
      end
    end
  endtask

  task automatic test_frame_counts();
    n_cmp++;
    if (got_cq.size() !== exp_cq.size()) begin
      n_err++;
      $display("FAIL frame_done_pulses: got %0d, want %0d", got_cq.size(), exp_cq.size());
    end
    for (int i = 0; i < exp_cq.size() && i < got_cq.size(); i++) begin
      n_cmp++;
      if (got_cq[i] !== exp_cq[i]) begin
        n_err++;
        $display("FAIL frame_fg_cnt[%0d]: got %0d, want %0d", i, got_cq[i], exp_cq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_erode_border();
    test_dilate_erode_single();
    test_majority();
    test_mode_midframe();
    test_clken_gap();
    test_back_to_back();
    tick();
    tick();
    test_pixels();
    test_frame_counts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
